// File: rtl/seq_pattern_detector_pkg.sv
// Shared defaults for the serial pattern detector and its history register.
package seq_pattern_detector_pkg;

    localparam int unsigned PAT_LEN_DEF = 4;
    localparam int unsigned CNT_W_DEF   = 8;
    localparam logic [PAT_LEN_DEF-1:0] PAT_DEFAULT_DEF = 4'b1001;
    localparam int unsigned FILL_W = $clog2(PAT_LEN_DEF + 1);

endpackage

// File: rtl/seq_pattern_detector_if.sv
// Bit-stream, control and status signals of the pattern detector.
interface seq_pattern_detector_if #(
    parameter int unsigned PAT_LEN = 4,
    parameter int unsigned CNT_W   = 8
) ();

    logic                             InputBit;
    logic                             InValid;
    logic                             Overlap;
    logic                             PatLoad;
    logic [PAT_LEN-1:0]               Pattern;
    logic                             Detected1;
    logic [CNT_W-1:0]                 MatchCount;
    logic [$clog2(PAT_LEN+1)-1:0]     FillLevel;

    modport master (
        output InputBit, InValid, Overlap, PatLoad, Pattern,
        input  Detected1, MatchCount, FillLevel
    );

    modport slave (
        input  InputBit, InValid, Overlap, PatLoad, Pattern,
        output Detected1, MatchCount, FillLevel
    );

endinterface

// File: rtl/seq_history_shreg.sv
// Shift register with enable, synchronous clear and a saturating fill counter;
// exposes the would-be next contents so the caller can compare before committing.
module seq_history_shreg
    import seq_pattern_detector_pkg::*;
#(
    parameter int unsigned N      = PAT_LEN_DEF,
    parameter int unsigned HFILL_W = FILL_W
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               shift_en,
    input  logic               clear,
    input  logic               din,
    output logic [HFILL_W-1:0] fill,
    output logic [N-1:0]       hist_next_c,
    output logic [HFILL_W-1:0] fill_next_c
);

    logic [N-1:0] hist;

    always_comb begin
        hist_next_c = {hist[N-2:0], din};
        fill_next_c = (fill == HFILL_W'(N)) ? fill : fill + HFILL_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (!Reset || clear) begin
            hist <= '0;
            fill <= '0;
        end else if (shift_en) begin
            hist <= hist_next_c;
            fill <= fill_next_c;
        end
    end

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial detector for a runtime-loadable PAT_LEN-bit pattern with overlapping
// or non-overlapping matching, registered detect pulse and saturating count.
module seq_pattern_detector
    import seq_pattern_detector_pkg::*;
#(
    parameter int unsigned        PAT_LEN     = PAT_LEN_DEF,
    parameter logic [PAT_LEN-1:0] PAT_DEFAULT = PAT_LEN'(PAT_DEFAULT_DEF),
    parameter int unsigned        CNT_W       = CNT_W_DEF
) (
    input  logic                  CLK,
    input  logic                  Reset,
    seq_pattern_detector_if.slave bus
);

    localparam int unsigned HFILL_W = $clog2(PAT_LEN + 1);

    logic [PAT_LEN-1:0] pat_q;
    logic               det_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [HFILL_W-1:0] fill;
    logic [PAT_LEN-1:0] hist_next_c;
    logic [HFILL_W-1:0] fill_next_c;
    logic               match_c;
    logic               accept_c;
    logic               hist_clear_c;

    // A load takes precedence over the bit offered on the same edge.
    always_comb begin
        accept_c     = bus.InValid && !bus.PatLoad;
        match_c      = accept_c && (fill_next_c == HFILL_W'(PAT_LEN))
                                && (hist_next_c == pat_q);
        hist_clear_c = bus.PatLoad || (match_c && !bus.Overlap);
    end

    seq_history_shreg #(
        .N       (PAT_LEN),
        .HFILL_W (HFILL_W)
    ) u_hist (
        .CLK         (CLK),
        .Reset       (Reset),
        .shift_en    (accept_c),
        .clear       (hist_clear_c),
        .din         (bus.InputBit),
        .fill        (fill),
        .hist_next_c (hist_next_c),
        .fill_next_c (fill_next_c)
    );

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            pat_q <= PAT_DEFAULT;
            det_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            det_q <= match_c;
            if (bus.PatLoad) begin
                pat_q <= bus.Pattern;
            end
            if (match_c && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.Detected1  = det_q;
    assign bus.MatchCount = cnt_q;
    assign bus.FillLevel  = fill;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: directed scenarios plus a randomized stream,
// checked every cycle against a bit-list reference model.
module tb_seq_pattern_detector;

    localparam int unsigned PL = 4;

    logic CLK = 1'b0;
    logic Reset;

    always #5 CLK = ~CLK;

    seq_pattern_detector_if #(.PAT_LEN(PL), .CNT_W(8)) bus0 ();
    seq_pattern_detector_if #(.PAT_LEN(PL), .CNT_W(2)) bus1 ();

    assign bus1.InputBit = bus0.InputBit;
    assign bus1.InValid  = bus0.InValid;
    assign bus1.Overlap  = bus0.Overlap;
    assign bus1.PatLoad  = bus0.PatLoad;
    assign bus1.Pattern  = bus0.Pattern;

    seq_pattern_detector #(.PAT_LEN(PL), .PAT_DEFAULT(4'b1001), .CNT_W(8)) dut0 (
        .CLK (CLK), .Reset (Reset), .bus (bus0)
    );

    seq_pattern_detector #(.PAT_LEN(PL), .PAT_DEFAULT(4'b1001), .CNT_W(2)) dut1 (
        .CLK (CLK), .Reset (Reset), .bus (bus1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: every bit accepted since the last clear, newest at the back.
    bit          mq[$];
    logic [PL-1:0] pat_m;
    int          cnt_m;
    logic        det_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s t=%0t got=%0d expected=%0d", tag, $time, got, exp);
        else
            n_pass++;
    endtask

    function automatic bit tail_matches();
        int n = mq.size();
        if (n < PL) return 1'b0;
        for (int i = 0; i < PL; i++)
            if (mq[n-1-i] != pat_m[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int sat(input int v, input int w);
        int mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic int fill_m();
        return (mq.size() > PL) ? PL : mq.size();
    endfunction

    task automatic model(input logic rst, input logic pl, input logic [PL-1:0] pat,
                         input logic iv, input logic b, input logic ov);
        if (!rst) begin
            mq.delete(); pat_m = 4'b1001; cnt_m = 0; det_m = 1'b0;
        end else if (pl) begin
            mq.delete(); pat_m = pat; det_m = 1'b0;
        end else if (iv) begin
            mq.push_back(b);
            det_m = tail_matches();
            if (det_m) begin
                cnt_m++;
                if (!ov) mq.delete();
            end
        end else begin
            det_m = 1'b0;
        end
    endtask

    task automatic step(input logic rst, input logic pl, input logic [PL-1:0] pat,
                        input logic iv, input logic b, input logic ov);
        @(negedge CLK);
        Reset = rst; bus0.PatLoad = pl; bus0.Pattern = pat;
        bus0.InValid = iv; bus0.InputBit = b; bus0.Overlap = ov;
        @(posedge CLK);
        model(rst, pl, pat, iv, b, ov);
        #1;
        check("det8",  32'(bus0.Detected1),  32'(det_m));
        check("cnt8",  32'(bus0.MatchCount), 32'(sat(cnt_m, 8)));
        check("fill8", 32'(bus0.FillLevel),  32'(fill_m()));
        check("det2",  32'(bus1.Detected1),  32'(det_m));
        check("cnt2",  32'(bus1.MatchCount), 32'(sat(cnt_m, 2)));
        check("fill2", 32'(bus1.FillLevel),  32'(fill_m()));
    endtask

    task automatic send(input logic b, input logic ov);
        step(1'b1, 1'b0, '0, 1'b1, b, ov);
    endtask

    task automatic idle(input logic ov);
        step(1'b1, 1'b0, '0, 1'b0, 1'b1, ov);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b1, 4'b0110, 1'b1, 1'b1, 1'b1);
    endtask

    logic [6:0] s7;
    logic [3:0] s4;

    initial begin
        Reset = 1'b0; bus0.PatLoad = 1'b0; bus0.Pattern = '0;
        bus0.InValid = 1'b0; bus0.InputBit = 1'b0; bus0.Overlap = 1'b1;

        // Reset state, including reset overriding a concurrent load.
        do_reset(); do_reset();
        check("rst_cnt",  32'(bus0.MatchCount), 32'd0);
        check("rst_fill", 32'(bus0.FillLevel),  32'd0);

        // 1001001 with overlap: two detects.
        s7 = 7'b1001001;
        for (int i = 6; i >= 0; i--) send(s7[i], 1'b1);
        check("ovl_cnt", 32'(bus0.MatchCount), 32'd2);

        // Same stream without overlap: one detect, three bits left over.
        do_reset();
        for (int i = 6; i >= 0; i--) send(s7[i], 1'b0);
        check("novl_cnt",  32'(bus0.MatchCount), 32'd1);
        check("novl_fill", 32'(bus0.FillLevel),  32'd3);

        // Gaps of idle cycles between bits.
        do_reset();
        s4 = 4'b1001;
        for (int i = 3; i >= 0; i--) begin
            send(s4[i], 1'b1);
            for (int g = 0; g < 3; g++) idle(1'b1);
        end
        check("gap_cnt", 32'(bus0.MatchCount), 32'd1);

        // Load with a concurrent valid bit discards that bit; count retained.
        step(1'b1, 1'b1, 4'b0110, 1'b1, 1'b1, 1'b1);
        check("load_fill", 32'(bus0.FillLevel), 32'd0);
        s4 = 4'b0110;
        for (int i = 3; i >= 0; i--) send(s4[i], 1'b1);
        check("load_cnt", 32'(bus0.MatchCount), 32'd2);

        // All-ones with overlap: back-to-back pulses, 2-bit counter saturates.
        do_reset();
        step(1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) send(1'b1, 1'b1);
        check("sat_cnt8", 32'(bus0.MatchCount), 32'd5);
        check("sat_cnt2", 32'(bus1.MatchCount), 32'd3);

        // One-cycle reset mid-stream loses history and restores default pattern.
        do_reset();
        send(1'b1, 1'b1); send(1'b0, 1'b1); send(1'b0, 1'b1);
        do_reset();
        send(1'b1, 1'b1);
        check("mid_fill", 32'(bus0.FillLevel),  32'd1);
        check("mid_cnt",  32'(bus0.MatchCount), 32'd0);
        send(1'b0, 1'b1); send(1'b0, 1'b1); send(1'b1, 1'b1);
        check("mid_dflt", 32'(bus0.Detected1), 32'd1);

        // All-zero pattern must not match a partially filled history.
        step(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) send(1'b0, 1'b1);
        check("zero_early", 32'(bus0.MatchCount), 32'd1);
        send(1'b0, 1'b1);
        check("zero_full", 32'(bus0.Detected1), 32'd1);

        // Randomized stream with occasional resets, loads and overlap changes.
        begin
            logic ov = 1'b1;
            for (int c = 0; c < 3000; c++) begin
                int unsigned r = $urandom_range(0, 99);
                if ($urandom_range(0, 19) == 0) ov = ~ov;
                step(r == 0 ? 1'b0 : 1'b1,
                     (r >= 1 && r < 4) ? 1'b1 : 1'b0,
                     PL'($urandom),
                     ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                     1'($urandom),
                     ov);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
